// File: rtl/serv_irq_ctrl.sv
// rtl/serv_irq_ctrl.sv - machine timer and external interrupt aggregator for the SERV CSR unit
// Wishbone-classic register slave driving the mtip/meip pending lines.
module serv_irq_ctrl #(
  parameter int NIRQ = 8,
  parameter int PW   = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [2:0]      i_wb_adr,
  input  logic [31:0]     i_wb_dat,
  input  logic [3:0]      i_wb_sel,
  input  logic            i_wb_we,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  output logic [31:0]     o_wb_rdt,
  output logic            o_wb_ack,
  input  logic [NIRQ-1:0] i_irq,
  output logic            o_mtip,
  output logic            o_meip
);

  logic [63:0]     r_mtime;
  logic [63:0]     r_mtimecmp;
  logic [PW-1:0]   r_prescale;
  logic [PW-1:0]   r_pcnt;
  logic [31:0]     r_hi_shadow;
  logic [NIRQ-1:0] r_pending;
  logic [NIRQ-1:0] r_enable;
  logic [NIRQ-1:0] r_edge;
  logic [NIRQ-1:0] r_sync1;
  logic [NIRQ-1:0] r_s;
  logic [NIRQ-1:0] r_sd;

  logic            w_req;
  logic            w_wr;
  logic [7:0]      w_we;
  logic [31:0]     w_bmask;
  logic            w_tick;
  logic [NIRQ-1:0] w_clr;
  logic [NIRQ-1:0] w_rise;
  logic [31:0]     w_prescale32;
  logic [31:0]     w_pending32;
  logic [31:0]     w_enable32;
  logic [31:0]     w_edge32;
  logic [31:0]     w_rdata;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [31:0] mask);
    return (old & ~mask) | (dat & mask);
  endfunction

  assign w_req   = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign w_wr    = w_req & i_wb_we;
  assign w_we    = w_wr ? (8'd1 << i_wb_adr) : 8'd0;
  assign w_bmask = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
  assign w_tick  = (r_pcnt == r_prescale);
  assign w_clr   = w_we[5] ? (i_wb_dat[NIRQ-1:0] & w_bmask[NIRQ-1:0]) : '0;
  assign w_rise  = r_s & ~r_sd;

  always_comb begin
    w_prescale32 = '0;
    w_pending32  = '0;
    w_enable32   = '0;
    w_edge32     = '0;
    w_prescale32[PW-1:0] = r_prescale;
    w_pending32[NIRQ-1:0] = r_pending;
    w_enable32[NIRQ-1:0]  = r_enable;
    w_edge32[NIRQ-1:0]    = r_edge;
  end

  always_comb begin
    w_rdata = '0;
    case (i_wb_adr)
      3'd0: w_rdata = r_mtime[31:0];
      3'd1: w_rdata = r_hi_shadow;
      3'd2: w_rdata = r_mtimecmp[31:0];
      3'd3: w_rdata = r_mtimecmp[63:32];
      3'd4: w_rdata = w_prescale32;
      3'd5: w_rdata = w_pending32;
      3'd6: w_rdata = w_enable32;
      default: w_rdata = w_edge32;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wb_ack    <= 1'b0;
      o_wb_rdt    <= '0;
      r_hi_shadow <= '0;
    end else begin
      o_wb_ack <= w_req;
      if (w_req)
        o_wb_rdt <= w_rdata;
      // Latching the upper half on a low read makes lo-then-hi a coherent 64-bit snapshot
      if (w_req && !i_wb_we && i_wb_adr == 3'd0)
        r_hi_shadow <= r_mtime[63:32];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_prescale <= '0;
      r_pcnt     <= '0;
    end else begin
      if (w_we[0] || w_we[1]) begin
        if (w_we[0]) r_mtime[31:0]  <= merge(r_mtime[31:0], i_wb_dat, w_bmask);
        if (w_we[1]) r_mtime[63:32] <= merge(r_mtime[63:32], i_wb_dat, w_bmask);
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end
      if (w_we[2]) r_mtimecmp[31:0]  <= merge(r_mtimecmp[31:0], i_wb_dat, w_bmask);
      if (w_we[3]) r_mtimecmp[63:32] <= merge(r_mtimecmp[63:32], i_wb_dat, w_bmask);
      if (w_we[4])
        r_prescale <= (r_prescale & ~w_bmask[PW-1:0]) | (i_wb_dat[PW-1:0] & w_bmask[PW-1:0]);
      if (w_we[4] || w_tick)
        r_pcnt <= '0;
      else
        r_pcnt <= r_pcnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_enable  <= '0;
      r_edge    <= '0;
      r_pending <= '0;
      r_sync1   <= '0;
      r_s       <= '0;
      r_sd      <= '0;
      o_mtip    <= 1'b0;
      o_meip    <= 1'b0;
    end else begin
      r_sync1 <= i_irq;
      r_s     <= r_sync1;
      r_sd    <= r_s;
      if (w_we[6])
        r_enable <= (r_enable & ~w_bmask[NIRQ-1:0]) | (i_wb_dat[NIRQ-1:0] & w_bmask[NIRQ-1:0]);
      if (w_we[7])
        r_edge <= (r_edge & ~w_bmask[NIRQ-1:0]) | (i_wb_dat[NIRQ-1:0] & w_bmask[NIRQ-1:0]);
      // Edge lines: a new rising edge wins over a simultaneous software clear
      r_pending <= (~r_edge & r_s) | (r_edge & ((r_pending & ~w_clr) | w_rise));
      o_mtip <= (r_mtime >= r_mtimecmp);
      o_meip <= |(r_pending & r_enable);
    end
  end

endmodule

// File: tb/tb_serv_irq_ctrl.sv
// tb/tb_serv_irq_ctrl.sv - scoreboard bench for serv_irq_ctrl
module tb_serv_irq_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic [7:0]  irq;
  logic        mtip;
  logic        meip;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       name;
  } rd_item_t;

  typedef struct {
    logic [2:0] exp;
    logic [2:0] mask;
    string      name;
  } pin_item_t;

  rd_item_t  rd_q[$];
  pin_item_t pin_q[$];

  serv_irq_ctrl #(.NIRQ(8), .PW(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel), .i_wb_we(wb_we),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .o_wb_rdt(wb_rdt), .o_wb_ack(wb_ack),
    .i_irq(irq), .o_mtip(mtip), .o_meip(meip)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Monitor: pops expectations whenever the DUT acks or a pin check is queued
  initial begin
    rd_item_t  it;
    pin_item_t pt;
    logic [2:0] act;
    forever begin
      @(negedge clk);
      if (!rst && wb_ack === 1'b1) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stray_ack: ack with no outstanding request");
        end else begin
          it = rd_q.pop_front();
          if (it.chk) begin
            checks++;
            if (wb_rdt !== it.exp) begin
              errors++;
              $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, wb_rdt, it.exp);
            end
          end
        end
      end
      if (pin_q.size() > 0) begin
        pt = pin_q.pop_front();
        act = {wb_ack, mtip, meip};
        checks++;
        if ((act & pt.mask) !== (pt.exp & pt.mask)) begin
          errors++;
          $display("FAIL %s: {ack,mtip,meip} got %b expected %b (mask %b)",
                   pt.name, act, pt.exp, pt.mask);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic bus(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                     input logic we);
    int n;
    @(posedge clk);
    #1;
    wb_adr = adr;
    wb_dat = dat;
    wb_sel = sel;
    wb_we  = we;
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (wb_ack !== 1'b1 && n < 8);
    if (wb_ack !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL bus_timeout: adr %0d no ack after %0d cycles", adr, n);
    end
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
    rd_item_t it;
    it.chk = 1'b0;
    it.exp = '0;
    it.name = "write";
    rd_q.push_back(it);
    bus(adr, dat, sel, 1'b1);
  endtask

  task automatic rd(input logic [2:0] adr, input logic [31:0] exp, input string name);
    rd_item_t it;
    it.chk = 1'b1;
    it.exp = exp;
    it.name = name;
    rd_q.push_back(it);
    bus(adr, 32'h0, 4'hF, 1'b0);
  endtask

  task automatic pin(input logic [2:0] exp, input logic [2:0] mask, input string name);
    pin_item_t pt;
    pt.exp = exp;
    pt.mask = mask;
    pt.name = name;
    pin_q.push_back(pt);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 0;
    wb_adr = 0;
    wb_dat = 0;
    wb_sel = 0;
    wb_we = 0;
    wb_cyc = 0;
    wb_stb = 0;
    irq = 0;
    #3 rst = 1;
    step();
    pin(3'b000, 3'b111, "reset_outputs");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    pin(3'b000, 3'b111, "post_reset_outputs");

    // mtime counts one per cycle from reset; reads land every second cycle
    rd(3'd2, 32'hFFFFFFFF, "mtimecmp_lo_reset");
    rd(3'd3, 32'hFFFFFFFF, "mtimecmp_hi_reset");
    rd(3'd0, 32'd5, "mtime_count_a");
    rd(3'd0, 32'd7, "mtime_count_b");
    rd(3'd1, 32'd0, "mtime_hi_reset");
    rd(3'd4, 32'd0, "prescale_reset");

    // Prescale 3: one increment per 4 cycles, carry into the upper word
    wr(3'd4, 32'd255);
    wr(3'd1, 32'd1);
    wr(3'd0, 32'hFFFFFFFE);
    wr(3'd4, 32'd3);
    rd(3'd0, 32'hFFFFFFFE, "ps_lo_0");
    rd(3'd0, 32'hFFFFFFFE, "ps_lo_1");
    rd(3'd0, 32'hFFFFFFFF, "ps_lo_2");
    rd(3'd0, 32'hFFFFFFFF, "ps_lo_3");
    rd(3'd0, 32'h00000000, "ps_lo_carry");
    rd(3'd1, 32'h00000002, "ps_hi_carry");

    // Coherent read: hi returns the shadow taken at the lo read
    wr(3'd4, 32'd255);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'hFFFFFFFF);
    rd(3'd0, 32'hFFFFFFFF, "coh_lo");
    wr(3'd4, 32'd0);
    rd(3'd1, 32'h00000000, "coh_hi_shadow");
    rd(3'd0, 32'h00000002, "coh_lo_live");
    rd(3'd1, 32'h00000001, "coh_hi_new");

    // Timer compare
    wr(3'd4, 32'd255);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd0);
    wr(3'd2, 32'd10);
    wr(3'd3, 32'd0);
    pin(3'b000, 3'b010, "mtip_setup_low");
    wr(3'd4, 32'd0);
    repeat (9) step();
    pin(3'b000, 3'b010, "mtip_mtime9");
    step();
    pin(3'b000, 3'b010, "mtip_mtime10_edge");
    step();
    pin(3'b010, 3'b010, "mtip_rise");
    wr(3'd3, 32'd1);
    pin(3'b010, 3'b010, "mtip_before_fall");
    step();
    pin(3'b000, 3'b010, "mtip_fall");

    // Edge-mode interrupt on line 2
    wr(3'd7, 32'h04);
    wr(3'd6, 32'h04);
    irq[2] = 1'b1;
    repeat (3) step();
    irq[2] = 1'b0;
    pin(3'b000, 3'b001, "meip_edge_k2");
    step();
    pin(3'b001, 3'b001, "meip_edge_k3");
    repeat (4) step();
    pin(3'b001, 3'b001, "meip_edge_hold");
    rd(3'd5, 32'h04, "edge_pending");
    wr(3'd5, 32'h04);
    pin(3'b001, 3'b001, "meip_before_clear");
    step();
    pin(3'b000, 3'b001, "meip_cleared");

    // New edge coinciding with a software clear keeps the bit set
    irq[2] = 1'b1;
    step();
    wr(3'd5, 32'h04);
    pin(3'b000, 3'b001, "meip_collide_k");
    step();
    pin(3'b001, 3'b001, "meip_collide_set");
    rd(3'd5, 32'h04, "collide_pending");
    irq[2] = 1'b0;
    repeat (4) step();
    wr(3'd5, 32'h04);
    rd(3'd5, 32'h00, "edge_cleared");

    // Level mode and enable mask on line 0
    wr(3'd7, 32'h00);
    wr(3'd6, 32'h00);
    irq[0] = 1'b1;
    repeat (6) step();
    pin(3'b000, 3'b001, "meip_masked");
    rd(3'd5, 32'h01, "level_pending");
    wr(3'd6, 32'h01);
    pin(3'b000, 3'b001, "meip_enable_k");
    step();
    pin(3'b001, 3'b001, "meip_enable_k1");
    irq[0] = 1'b0;
    step();
    pin(3'b001, 3'b001, "meip_drop_k");
    step();
    pin(3'b001, 3'b001, "meip_drop_k1");
    step();
    pin(3'b001, 3'b001, "meip_drop_k2");
    step();
    pin(3'b000, 3'b001, "meip_drop_k3");

    // Byte enables and unimplemented bits
    wr(3'd2, 32'h11223344);
    wr(3'd2, 32'hAABBCCDD, 4'b0101);
    rd(3'd2, 32'h11BB33DD, "sel_mtimecmp_lo");
    wr(3'd7, 32'hFFFFFFFF);
    rd(3'd7, 32'h000000FF, "edge_unimpl_bits");
    wr(3'd7, 32'h0);
    wr(3'd6, 32'hFF, 4'b0000);
    rd(3'd6, 32'h01, "enable_sel_none");
    wr(3'd4, 32'hFFFFFF05, 4'b0001);
    rd(3'd4, 32'h05, "prescale_unimpl_bits");

    repeat (4) step();
    checks++;
    if (rd_q.size() != 0 || pin_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: rd %0d pin %0d left, expected 0 0", rd_q.size(), pin_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
